seq_detect_param: RTL and testbench

//  Parametrised streaming sequence detector. Compares the most recent valid input

---
 rtl/seq_detect_param.sv | 96 +++++++++
 tb/tb_seq_detect_param.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Streaming sequence detector: matches the newest valid words against a
// programmable pattern of 1..MAX_LEN words, pulsing flag and counting matches.
module seq_detect_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned OVERLAP = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            data,
  input  logic                         data_vld,
  input  logic                         pat_wr,
  input  logic [$clog2(MAX_LEN)-1:0]   pat_addr,
  input  logic [DATA_W-1:0]            pat_wdata,
  input  logic [$clog2(MAX_LEN+1)-1:0] pat_len,
  input  logic                         cnt_clr,
  output logic                         flag,
  output logic [CNT_W-1:0]             match_cnt
);

  localparam int unsigned AW = $clog2(MAX_LEN);
  localparam int unsigned LW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {IDLE, ARMED, HIT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pat_q  [MAX_LEN];
  logic [DATA_W-1:0] pat_d  [MAX_LEN];
  logic [DATA_W-1:0] hist_q [MAX_LEN];
  logic [DATA_W-1:0] hist_d [MAX_LEN];
  logic [DATA_W-1:0] win    [MAX_LEN];
  logic [LW-1:0]     fill_q, fill_d, fill_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              len_ok, words_eq, match;

  // win[0] is the incoming word, win[k] the word seen k valid cycles earlier.
  always_comb begin
    win[0] = data;
    for (int unsigned i = 1; i < MAX_LEN; i++) win[i] = hist_q[i-1];
  end

  always_comb begin
    len_ok   = (pat_len != '0) && (32'(pat_len) <= MAX_LEN);
    fill_nxt = fill_q;
    if (data_vld && (32'(fill_q) < MAX_LEN)) fill_nxt = fill_q + LW'(1);
    // Word of age i lines up with pattern entry pat_len-1-i.
    words_eq = 1'b1;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((i < 32'(pat_len)) && (win[i] != pat_q[AW'(32'(pat_len) - 1 - i)])) words_eq = 1'b0;
    end
    match = data_vld && !pat_wr && len_ok && (fill_nxt >= pat_len) && words_eq;
  end

  always_comb begin
    hist_d  = hist_q;
    pat_d   = pat_q;
    fill_d  = fill_nxt;
    cnt_d   = cnt_q;
    state_d = IDLE;
    if (data_vld) hist_d = win;
    if (pat_wr) begin
      fill_d = '0;
      if (32'(pat_addr) < MAX_LEN) pat_d[pat_addr] = pat_wdata;
    end else if (match && (OVERLAP == 0)) begin
      fill_d = '0;
    end
    if (cnt_clr) cnt_d = '0;
    else if (match && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    if (pat_wr) state_d = IDLE;
    else if (match) state_d = HIT;
    else if (len_ok && (fill_d >= pat_len)) state_d = ARMED;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        hist_q[i] <= '0;
        pat_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
    end
  end

  assign flag      = (state_q == HIT);
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (overlap, non-overlap, 2-bit counter)
// checked against directed expectations and a queue-based reference model.
module tb_seq_detect_param;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data, pat_wdata;
  logic        data_vld, pat_wr, cnt_clr;
  logic [2:0]  pat_addr;
  logic [3:0]  pat_len;
  logic        flag0, flag1, flag2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;
  int errors = 0;
  int checks = 0;

  logic [7:0] mpat [8];
  logic [7:0] hist [$];
  int fresh    [3];
  bit exp_flag [3];
  int exp_cnt  [3];
  int ov   [3] = '{1, 0, 1};
  int cmax [3] = '{65535, 65535, 3};

  always #5 clk = ~clk;

  seq_detect_param #(.DATA_W(8), .MAX_LEN(8), .OVERLAP(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_vld(data_vld), .pat_wr(pat_wr),
    .pat_addr(pat_addr), .pat_wdata(pat_wdata), .pat_len(pat_len), .cnt_clr(cnt_clr),
    .flag(flag0), .match_cnt(cnt0));
  seq_detect_param #(.DATA_W(8), .MAX_LEN(8), .OVERLAP(0), .CNT_W(16)) dut_nov (
    .clk(clk), .rst_n(rst_n), .data(data), .data_vld(data_vld), .pat_wr(pat_wr),
    .pat_addr(pat_addr), .pat_wdata(pat_wdata), .pat_len(pat_len), .cnt_clr(cnt_clr),
    .flag(flag1), .match_cnt(cnt1));
  seq_detect_param #(.DATA_W(8), .MAX_LEN(8), .OVERLAP(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .data(data), .data_vld(data_vld), .pat_wr(pat_wr),
    .pat_addr(pat_addr), .pat_wdata(pat_wdata), .pat_len(pat_len), .cnt_clr(cnt_clr),
    .flag(flag2), .match_cnt(cnt2));

  task automatic model_reset();
    hist.delete();
    for (int m = 0; m < 3; m++) begin
      fresh[m] = 0; exp_flag[m] = 1'b0; exp_cnt[m] = 0;
    end
    for (int k = 0; k < 8; k++) mpat[k] = 8'h00;
  endtask

  // Words since the last pattern write are kept in a queue; a match needs the tail
  // to equal the pattern and enough words since the last clear (or last match without overlap).
  task automatic model_edge();
    int L = int'(pat_len);
    bit win_ok = 1'b0;
    if (pat_wr) hist.delete();
    else if (data_vld) begin
      hist.push_back(data);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    if (data_vld && !pat_wr && L >= 1 && L <= 8 && hist.size() >= L) begin
      win_ok = 1'b1;
      for (int k = 0; k < L; k++)
        if (hist[hist.size() - L + k] !== mpat[k]) win_ok = 1'b0;
    end
    for (int m = 0; m < 3; m++) begin
      if (pat_wr) fresh[m] = 0;
      else if (data_vld) fresh[m]++;
      exp_flag[m] = win_ok && (fresh[m] >= L);
      if (exp_flag[m] && ov[m] == 0) fresh[m] = 0;
      if (cnt_clr) exp_cnt[m] = 0;
      else if (exp_flag[m] && exp_cnt[m] < cmax[m]) exp_cnt[m]++;
    end
    if (pat_wr) mpat[pat_addr] = pat_wdata;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic feed(input logic [7:0] d);
    data = d; data_vld = 1'b1; pat_wr = 1'b0; cnt_clr = 1'b0;
    step();
  endtask

  task automatic idle();
    data_vld = 1'b0; pat_wr = 1'b0; cnt_clr = 1'b0;
    step();
  endtask

  task automatic write_pat(input logic [2:0] a, input logic [7:0] w);
    pat_addr = a; pat_wdata = w; pat_wr = 1'b1; data_vld = 1'b0; cnt_clr = 1'b0;
    step();
    pat_wr = 1'b0;
  endtask

  task automatic load_pattern(input string s);
    pat_len = 4'(s.len());
    for (int i = 0; i < s.len(); i++) write_pat(3'(i), s[i]);
  endtask

  task automatic clear_counts();
    data_vld = 1'b0; pat_wr = 1'b0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data = '0; data_vld = 1'b0; pat_wr = 1'b0; pat_addr = '0;
    pat_wdata = '0; pat_len = '0; cnt_clr = 1'b0;
    model_reset();
    #23;
    checks++;
    if ({flag0, flag1, flag2} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {flag0, flag1, flag2});
    end
    checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || cnt2 !== 2'd0) begin
      errors++; $display("FAIL reset_cnts: got %0d/%0d/%0d want 0/0/0", cnt0, cnt1, cnt2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ascii();
    string s = "astattstateaa";
    load_pattern("state");
    clear_counts();
    for (int i = 0; i < s.len(); i++) begin
      feed(s[i]);
      checks++;
      if (flag0 !== (i == 10)) begin
        errors++; $display("FAIL ascii_flag word %0d: got %b want %b", i, flag0, (i == 10));
      end
    end
    idle();
    checks++;
    if (cnt0 !== 16'd1) begin
      errors++; $display("FAIL ascii_cnt: got %0d want 1", cnt0);
    end
  endtask

  task automatic test_overlap();
    logic [3:0] want_ov = 4'b1110;
    logic [3:0] want_nov = 4'b1010;
    load_pattern("aa");
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      feed(8'h61);
      checks++;
      if (flag0 !== want_ov[i]) begin
        errors++; $display("FAIL overlap_flag word %0d: got %b want %b", i, flag0, want_ov[i]);
      end
      checks++;
      if (flag1 !== want_nov[i]) begin
        errors++; $display("FAIL nonoverlap_flag word %0d: got %b want %b", i, flag1, want_nov[i]);
      end
    end
    idle();
    checks++;
    if (cnt0 !== 16'd3 || cnt1 !== 16'd2) begin
      errors++; $display("FAIL overlap_cnts: got %0d/%0d want 3/2", cnt0, cnt1);
    end
  endtask

  task automatic test_gaps();
    string s = "astattstateaa";
    load_pattern("state");
    clear_counts();
    for (int i = 0; i < s.len(); i++) begin
      feed(s[i]);
      checks++;
      if (flag0 !== (i == 10)) begin
        errors++; $display("FAIL gaps_flag word %0d: got %b want %b", i, flag0, (i == 10));
      end
      for (int g = 0; g < 3; g++) begin
        idle();
        checks++;
        if (flag0 !== 1'b0) begin
          errors++; $display("FAIL gaps_idle word %0d gap %0d: got %b want 0", i, g, flag0);
        end
      end
    end
    checks++;
    if (cnt0 !== 16'd1) begin
      errors++; $display("FAIL gaps_cnt: got %0d want 1", cnt0);
    end
  endtask

  task automatic test_reprogram();
    string a = "sta";
    string b = "te";
    string c = "state";
    load_pattern("state");
    clear_counts();
    for (int i = 0; i < a.len(); i++) feed(a[i]);
    write_pat(3'd0, 8'h73);
    for (int i = 0; i < b.len(); i++) begin
      feed(b[i]);
      checks++;
      if (flag0 !== 1'b0) begin
        errors++; $display("FAIL reprog_partial word %0d: got %b want 0", i, flag0);
      end
    end
    for (int i = 0; i < c.len(); i++) begin
      feed(c[i]);
      checks++;
      if (flag0 !== (i == 4)) begin
        errors++; $display("FAIL reprog_full word %0d: got %b want %b", i, flag0, (i == 4));
      end
    end
    checks++;
    if (cnt0 !== 16'd1) begin
      errors++; $display("FAIL reprog_cnt: got %0d want 1", cnt0);
    end
  endtask

  task automatic test_saturation();
    load_pattern("a");
    clear_counts();
    for (int i = 0; i < 6; i++) begin
      feed(8'h61);
      checks++;
      if (flag2 !== 1'b1) begin
        errors++; $display("FAIL sat_flag word %0d: got %b want 1", i, flag2);
      end
    end
    checks++;
    if (cnt2 !== 2'd3) begin
      errors++; $display("FAIL sat_cnt: got %0d want 3", cnt2);
    end
    data = 8'h61; data_vld = 1'b1; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    checks++;
    if (cnt2 !== 2'd0 || flag2 !== 1'b1) begin
      errors++; $display("FAIL sat_clr: got cnt=%0d flag=%b want cnt=0 flag=1", cnt2, flag2);
    end
  endtask

  task automatic test_reset_mid();
    string s = "stat";
    int pulses = 0;
    load_pattern("state");
    for (int i = 0; i < s.len(); i++) feed(s[i]);
    data_vld = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #4;
    checks++;
    if (flag0 !== 1'b0 || cnt0 !== 16'd0) begin
      errors++; $display("FAIL mid_reset: got flag=%b cnt=%0d want 0/0", flag0, cnt0);
    end
    rst_n = 1'b1;
    feed(8'h65);
    checks++;
    if (flag0 !== 1'b0) begin
      errors++; $display("FAIL mid_after_e: got %b want 0", flag0);
    end
    // reset leaves an all-zero pattern, so a single 0x00 word matches length 1
    pat_len = 4'd1;
    feed(8'h00);
    checks++;
    if (flag0 !== 1'b1) begin
      errors++; $display("FAIL mid_zero_pat: got %b want 1", flag0);
    end
    pat_len = 4'd0;
    for (int i = 0; i < 40; i++) begin
      feed(8'($urandom_range(1)));
      if (flag0 | flag1 | flag2) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL disabled_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_random();
    load_pattern("ab");
    for (int n = 0; n < 600; n++) begin
      data     = $urandom_range(1) ? 8'h61 : 8'h62;
      data_vld = ($urandom_range(99) < 70);
      cnt_clr  = ($urandom_range(99) < 3);
      pat_wr   = ($urandom_range(99) < 4);
      if (pat_wr) begin
        pat_addr  = 3'($urandom_range(7));
        pat_wdata = $urandom_range(1) ? 8'h61 : 8'h62;
        if ($urandom_range(9) == 0) pat_len = 4'($urandom_range(15));
        else pat_len = 4'($urandom_range(3, 1));
      end
      step();
      checks++;
      if (flag0 !== exp_flag[0]) begin
        errors++; $display("FAIL rnd_flag0 cyc %0d: got %b want %b", n, flag0, exp_flag[0]);
      end
      checks++;
      if (flag1 !== exp_flag[1]) begin
        errors++; $display("FAIL rnd_flag1 cyc %0d: got %b want %b", n, flag1, exp_flag[1]);
      end
      checks++;
      if (flag2 !== exp_flag[2]) begin
        errors++; $display("FAIL rnd_flag2 cyc %0d: got %b want %b", n, flag2, exp_flag[2]);
      end
      checks++;
      if (cnt0 !== 16'(exp_cnt[0])) begin
        errors++; $display("FAIL rnd_cnt0 cyc %0d: got %0d want %0d", n, cnt0, exp_cnt[0]);
      end
      checks++;
      if (cnt1 !== 16'(exp_cnt[1])) begin
        errors++; $display("FAIL rnd_cnt1 cyc %0d: got %0d want %0d", n, cnt1, exp_cnt[1]);
      end
      checks++;
      if (cnt2 !== 2'(exp_cnt[2])) begin
        errors++; $display("FAIL rnd_cnt2 cyc %0d: got %0d want %0d", n, cnt2, exp_cnt[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ascii();
    test_overlap();
    test_gaps();
    test_reprogram();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
